btn_debounce_sync: RTL and testbench

- Upstream conditioning stage for every pushbutton and voice-trigger input.
- Synchronises a raw asynchronous input into the clk domain, normalises its polarity, and qualifies it with a stable-time filter.
- Outputs a clean, glitch-free active-high level. That level feeds the single-pulse press detector, which converts it into one-cycle game commands (flap, start).
- Also reports filter activity and a saturating count of rejected bounces, for debug on HEX/LEDR.

---
 rtl/btn_debounce_sync_if.sv | 21 ++
 rtl/btn_debounce_sync.sv | 98 +++++++++
 tb/tb_btn_debounce_sync.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/btn_debounce_sync_if.sv
// Signal bundle between a raw button source and the debounce/synchroniser stage.
interface btn_debounce_sync_if;
  logic       btn_raw;
  logic       level;
  logic       busy;
  logic [7:0] bounce_cnt;

  modport master (
    output btn_raw,
    input  level,
    input  busy,
    input  bounce_cnt
  );

  modport slave (
    input  btn_raw,
    output level,
    output busy,
    output bounce_cnt
  );
endinterface

// File: rtl/btn_debounce_sync.sv
// Button conditioner: polarity normalise, 2-flop synchroniser, stable-time filter and a
// saturating count of aborted qualifications.
module btn_debounce_sync #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned CNT_W           = 16,
  parameter bit          IN_ACTIVE_LOW   = 1'b1
) (
  input logic                 clk,
  input logic                 reset,
  btn_debounce_sync_if.slave  bus
);

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {StLow, StChkH, StHigh, StChkL} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             s1_q, s1_d;
  logic             s2_q, s2_d;
  logic             level_q, level_d;
  logic             busy_q, busy_d;
  logic [7:0]       bounce_q, bounce_d;
  logic             bounce_evt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      state_q  <= StLow;
      cnt_q    <= '0;
      level_q  <= 1'b0;
      busy_q   <= 1'b0;
      bounce_q <= 8'd0;
    end else begin
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      level_q  <= level_d;
      busy_q   <= busy_d;
      bounce_q <= bounce_d;
    end
  end

  always_comb begin
    s1_d       = bus.btn_raw ^ IN_ACTIVE_LOW;
    s2_d       = s1_q;
    state_d    = state_q;
    cnt_d      = cnt_q;
    bounce_evt = 1'b0;

    unique case (state_q)
      StLow: begin
        if (s2_q) begin
          state_d = StChkH;
          cnt_d   = '0;
        end
      end
      StChkH: begin
        if (!s2_q) begin
          state_d    = StLow;
          bounce_evt = 1'b1;
        end else if (cnt_q == CntLast) begin
          state_d = StHigh;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StHigh: begin
        if (!s2_q) begin
          state_d = StChkL;
          cnt_d   = '0;
        end
      end
      StChkL: begin
        if (s2_q) begin
          state_d    = StHigh;
          bounce_evt = 1'b1;
        end else if (cnt_q == CntLast) begin
          state_d = StLow;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase

    // Outputs are decoded from the next state so they register in step with it.
    level_d  = (state_d == StHigh) || (state_d == StChkL);
    busy_d   = (state_d == StChkH) || (state_d == StChkL);
    bounce_d = (bounce_evt && (bounce_q != 8'hFF)) ? bounce_q + 8'd1 : bounce_q;
  end

  assign bus.level      = level_q;
  assign bus.busy       = busy_q;
  assign bus.bounce_cnt = bounce_q;

endmodule

// File: tb/tb_btn_debounce_sync.sv
// Directed bench: DUT A (active-low, 4-cycle filter) and DUT B (active-high, 1-cycle filter).
module tb_btn_debounce_sync;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   passed = 0;

  btn_debounce_sync_if bus_a ();
  btn_debounce_sync_if bus_b ();

  btn_debounce_sync #(
    .DEBOUNCE_CYCLES(4),
    .CNT_W          (16),
    .IN_ACTIVE_LOW  (1'b1)
  ) dut_a (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_a)
  );

  btn_debounce_sync #(
    .DEBOUNCE_CYCLES(1),
    .CNT_W          (16),
    .IN_ACTIVE_LOW  (1'b0)
  ) dut_b (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_b)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive DUT A with a logical press value (1 = pressed), then advance one edge.
  task automatic press_a(input logic n);
    bus_a.btn_raw = n ? 1'b0 : 1'b1;
    tick();
  endtask

  task automatic test_reset();
    reset         = 1'b0;
    bus_a.btn_raw = 1'b1;
    bus_b.btn_raw = 1'b0;
    tick();
    tick();
    checks++;
    if (bus_a.level !== 1'b0) $display("FAIL reset_level_a got %b want 0", bus_a.level);
    else passed++;
    checks++;
    if (bus_a.busy !== 1'b0) $display("FAIL reset_busy_a got %b want 0", bus_a.busy);
    else passed++;
    checks++;
    if (bus_a.bounce_cnt !== 8'd0)
      $display("FAIL reset_bounce_a got %0d want 0", bus_a.bounce_cnt);
    else passed++;
    checks++;
    if (bus_b.level !== 1'b0) $display("FAIL reset_level_b got %b want 0", bus_b.level);
    else passed++;
    reset = 1'b1;
    repeat (3) tick();
    checks++;
    if (bus_a.level !== 1'b0 || bus_a.busy !== 1'b0)
      $display("FAIL idle_a got level=%b busy=%b want 0/0", bus_a.level, bus_a.busy);
    else passed++;
  endtask

  task automatic test_press();
    for (int i = 0; i < 8; i++) begin
      press_a(1'b1);
      checks++;
      if (bus_a.level !== (i >= 6))
        $display("FAIL press_level i=%0d got %b want %b", i, bus_a.level, i >= 6);
      else passed++;
      checks++;
      if (bus_a.busy !== (i >= 2 && i <= 5))
        $display("FAIL press_busy i=%0d got %b want %b", i, bus_a.busy, i >= 2 && i <= 5);
      else passed++;
    end
  endtask

  task automatic test_release();
    for (int i = 0; i < 8; i++) begin
      press_a(1'b0);
      checks++;
      if (bus_a.level !== (i < 6))
        $display("FAIL release_level i=%0d got %b want %b", i, bus_a.level, i < 6);
      else passed++;
      checks++;
      if (bus_a.busy !== (i >= 2 && i <= 5))
        $display("FAIL release_busy i=%0d got %b want %b", i, bus_a.busy, i >= 2 && i <= 5);
      else passed++;
    end
    checks++;
    if (bus_a.bounce_cnt !== 8'd0)
      $display("FAIL release_bounce got %0d want 0", bus_a.bounce_cnt);
    else passed++;
  endtask

  task automatic test_bounce();
    logic       exp_busy;
    logic [7:0] exp_bnc;
    // s2 sees 1,1,0,1,1,... : abort at edge 4, requalify, level rises at edge 9.
    for (int i = 0; i < 10; i++) begin
      press_a(i != 2);
      exp_busy = (i == 2) || (i == 3) || (i >= 5 && i <= 8);
      exp_bnc  = (i >= 4) ? 8'd1 : 8'd0;
      checks++;
      if (bus_a.level !== (i >= 9))
        $display("FAIL bounce_level i=%0d got %b want %b", i, bus_a.level, i >= 9);
      else passed++;
      checks++;
      if (bus_a.busy !== exp_busy)
        $display("FAIL bounce_busy i=%0d got %b want %b", i, bus_a.busy, exp_busy);
      else passed++;
      checks++;
      if (bus_a.bounce_cnt !== exp_bnc)
        $display("FAIL bounce_cnt i=%0d got %0d want %0d", i, bus_a.bounce_cnt, exp_bnc);
      else passed++;
    end
    repeat (7) press_a(1'b0);
    checks++;
    if (bus_a.level !== 1'b0) $display("FAIL bounce_release got %b want 0", bus_a.level);
    else passed++;
  endtask

  task automatic test_saturate();
    for (int j = 0; j < 100; j++) begin
      press_a(1'b1);
      checks++;
      if (bus_a.level !== 1'b0) $display("FAIL glitch_level j=%0d got %b want 0", j, bus_a.level);
      else passed++;
      press_a(1'b0);
    end
    repeat (3) press_a(1'b0);
    checks++;
    if (bus_a.bounce_cnt !== 8'd101)
      $display("FAIL glitch_cnt_101 got %0d want 101", bus_a.bounce_cnt);
    else passed++;
    for (int j = 0; j < 200; j++) begin
      press_a(1'b1);
      checks++;
      if (bus_a.level !== 1'b0) $display("FAIL glitch_level2 j=%0d got %b want 0", j, bus_a.level);
      else passed++;
      press_a(1'b0);
    end
    repeat (3) press_a(1'b0);
    checks++;
    if (bus_a.bounce_cnt !== 8'd255)
      $display("FAIL glitch_cnt_sat got %0d want 255", bus_a.bounce_cnt);
    else passed++;
    checks++;
    if (bus_a.level !== 1'b0 || bus_a.busy !== 1'b0)
      $display("FAIL glitch_end got level=%b busy=%b want 0/0", bus_a.level, bus_a.busy);
    else passed++;
  endtask

  task automatic test_reset_mid();
    repeat (5) press_a(1'b1);
    checks++;
    if (bus_a.busy !== 1'b1) $display("FAIL mid_busy_pre got %b want 1", bus_a.busy);
    else passed++;
    reset = 1'b0;
    press_a(1'b1);
    checks++;
    if (bus_a.level !== 1'b0 || bus_a.busy !== 1'b0)
      $display("FAIL mid_reset got level=%b busy=%b want 0/0", bus_a.level, bus_a.busy);
    else passed++;
    checks++;
    if (bus_a.bounce_cnt !== 8'd0)
      $display("FAIL mid_reset_bounce got %0d want 0", bus_a.bounce_cnt);
    else passed++;
    reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      press_a(1'b1);
      checks++;
      if (bus_a.level !== (i >= 6))
        $display("FAIL restart_level i=%0d got %b want %b", i, bus_a.level, i >= 6);
      else passed++;
      checks++;
      if (bus_a.busy !== (i >= 2 && i <= 5))
        $display("FAIL restart_busy i=%0d got %b want %b", i, bus_a.busy, i >= 2 && i <= 5);
      else passed++;
    end
  endtask

  task automatic test_hold_b();
    bus_b.btn_raw = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      tick();
      checks++;
      if (bus_b.level !== (i >= 3))
        $display("FAIL hold_level_b i=%0d got %b want %b", i, bus_b.level, i >= 3);
      else passed++;
      checks++;
      if (bus_b.busy !== (i == 2))
        $display("FAIL hold_busy_b i=%0d got %b want %b", i, bus_b.busy, i == 2);
      else passed++;
    end
    checks++;
    if (bus_b.bounce_cnt !== 8'd0)
      $display("FAIL hold_bounce_b got %0d want 0", bus_b.bounce_cnt);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_press();
    test_release();
    test_bounce();
    test_saturate();
    test_reset_mid();
    test_hold_b();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
